// File: rtl/link_pkg.sv
// link_pkg: shared state encoding and default widths for the link arbiter.
package link_pkg;
  typedef enum logic [1:0] {IDLE, SREQ, MACK} state_e;
  localparam int DW_DEF = 8;
  localparam int CW_DEF = 8;
endpackage

// File: rtl/link_rr_pick.sv
// link_rr_pick: two-way round-robin pick; a tie goes to the requester not granted last.
module link_rr_pick (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] pick
);
  always_comb pick = &req ? (last ? 2'b01 : 2'b10) : req;
endmodule

// File: rtl/link_arbiter.sv
// link_arbiter: arbitrates two four-phase requesters onto one four-phase link slave.
module link_arbiter
  import link_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int CW = CW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    m_req,
  input  logic [DW-1:0] m_data0,
  input  logic [DW-1:0] m_data1,
  output logic [1:0]    m_ack,
  output logic          s_req,
  output logic [DW-1:0] s_data,
  input  logic          s_ack,
  output logic [1:0]    gnt,
  output logic          busy,
  output logic [CW-1:0] xfer_count
);
  state_e        state_q;
  logic          last_q;
  logic [1:0]    m_ack_q, gnt_q, pick;
  logic          s_req_q, busy_q;
  logic [DW-1:0] s_data_q;
  logic [CW-1:0] cnt_q, cnt_d;
  link_rr_pick u_pick (.req(m_req), .last(last_q), .pick(pick));
  assign cnt_d = cnt_q + CW'(1);
  // Owner releases only once both its request and the slave ack are low.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q  <= IDLE;
      last_q   <= 1'b1;
      m_ack_q  <= '0;
      gnt_q    <= '0;
      s_req_q  <= 1'b0;
      busy_q   <= 1'b0;
      s_data_q <= '0;
      cnt_q    <= '0;
    end else
      case (state_q)
        IDLE: if (|m_req) begin
          gnt_q    <= pick;
          s_data_q <= pick[1] ? m_data1 : m_data0;
          s_req_q  <= 1'b1;
          busy_q   <= 1'b1;
          state_q  <= SREQ;
        end
        SREQ: if (s_ack) begin
          s_req_q <= 1'b0;
          m_ack_q <= gnt_q;
          state_q <= MACK;
        end
        MACK: if (!(|(m_req & gnt_q)) && !s_ack) begin
          m_ack_q <= '0;
          gnt_q   <= '0;
          last_q  <= gnt_q[1];
          cnt_q   <= cnt_d;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
  assign m_ack      = m_ack_q;
  assign gnt        = gnt_q;
  assign s_req      = s_req_q;
  assign busy       = busy_q;
  assign s_data     = s_data_q;
  assign xfer_count = cnt_q;
endmodule

// File: tb/tb_link_arbiter.sv
// tb_link_arbiter: random four-phase masters and slave, transaction model feeding a scoreboard.
module tb_link_arbiter;
  localparam int DW = 8;
  localparam int CW = 2;
  logic clk = 0, rst = 0;
  logic [1:0] m_req, m_ack, gnt;
  logic [DW-1:0] m_data0, m_data1, s_data;
  logic s_req, s_ack, busy;
  logic [CW-1:0] xfer_count;
  bit stop = 0, fin = 0, tie_miss = 0, end_miss = 0;
  int sto = 0;
  always #5 clk = ~clk;
  link_arbiter #(.DW(DW), .CW(CW)) dut (
    .clk(clk), .rst(rst), .m_req(m_req), .m_data0(m_data0), .m_data1(m_data1),
    .m_ack(m_ack), .s_req(s_req), .s_data(s_data), .s_ack(s_ack),
    .gnt(gnt), .busy(busy), .xfer_count(xfer_count)
  );
  for (genvar g = 0; g < 2; g++) begin : mst
    logic r = 0;
    logic [DW-1:0] d = 0;
    bit idle = 1;
    int to = 0;
    initial begin
      int t;
      @(negedge rst);
      while (!stop) begin
        idle = 1;
        repeat ($urandom_range(0, 3)) @(posedge clk);
        if (stop) break;
        #1 d = DW'($urandom); r = 1; idle = 0;
        t = 0;
        while (!m_ack[g] && !(r == 0 && !busy) && t < 400) begin
          @(negedge clk); t++;
          if (r && gnt[g] && !m_ack[g] && $urandom_range(0, 5) == 0) begin
            @(posedge clk); #1 r = 0; d = DW'($urandom);
          end
        end
        if (t >= 400) to++;
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1 r = 0; d = DW'($urandom);
        t = 0;
        while (m_ack[g] && t < 400) begin @(negedge clk); t++; end
        if (t >= 400) to++;
      end
      idle = 1;
    end
  end
  assign m_req   = {mst[1].r, mst[0].r};
  assign m_data0 = mst[0].d;
  assign m_data1 = mst[1].d;
  initial begin
    int t;
    s_ack = 0;
    @(negedge rst);
    while (!stop || busy) begin
      @(negedge clk);
      if (s_req) begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1 s_ack = 1;
        t = 0;
        while (s_req && t < 400) begin @(negedge clk); t++; end
        if (t >= 400) sto++;
        repeat ($urandom_range(0, 5)) @(posedge clk);
        #1 s_ack = 0;
      end
    end
  end
  typedef struct {int w; logic [DW-1:0] d; int cyc;} gnt_t;
  typedef struct {int c; int cyc;} done_t;
  gnt_t gq[$];
  int aq[$];
  done_t dq[$];
  int ph, lst, own, cnt, cyc = 0, w;
  // Transaction-level reference: one grant per free-link request, tie to the requester not served last.
  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      ph = 0; lst = 1; cnt = 0;
      gq.delete(); aq.delete(); dq.delete();
    end else begin
      cyc++;
      if (ph == 0 && m_req != 0) begin
        w = (m_req == 2'b11) ? 1 - lst : (m_req[1] ? 1 : 0);
        gq.push_back('{w, w == 1 ? m_data1 : m_data0, cyc});
        own = w; ph = 1;
      end else if (ph == 1 && s_ack) begin
        aq.push_back(cyc); ph = 2;
      end else if (ph == 2 && !m_req[own] && !s_ack) begin
        cnt = (cnt + 1) % (1 << CW); lst = own;
        dq.push_back('{cnt, cyc}); ph = 0;
      end
    end
  end
  int n_chk = 0, n_fail = 0;
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask
  initial begin
    bit p_sreq = 0, p_mack = 0, p_busy = 0, have = 0;
    gnt_t cur, e;
    done_t dn;
    int a;
    while (!fin) begin
      @(negedge clk or posedge rst);
      if (rst) begin
        #1;
        chk("reset_outputs", {m_ack, s_req, s_data, gnt, busy, xfer_count}, 0);
        p_sreq = 0; p_mack = 0; p_busy = 0; have = 0;
      end else begin
        if (s_req && !p_sreq) begin
          if (gq.size() == 0) chk("grant_expected", 0, 1);
          else begin
            e = gq.pop_front();
            chk("gnt", gnt, 64'd1 << e.w);
            chk("s_data", s_data, e.d);
            chk("grant_latency", cyc, e.cyc);
            cur = e; have = 1;
          end
        end
        if (busy && have) chk("s_data_hold", s_data, cur.d);
        if (m_ack != 0 && !p_mack) begin
          if (aq.size() == 0) chk("ack_expected", 0, 1);
          else begin
            a = aq.pop_front();
            chk("m_ack", m_ack, 64'd1 << cur.w);
            chk("ack_latency", cyc, a);
            chk("s_req_low_in_mack", s_req, 0);
          end
        end
        if (!busy && p_busy) begin
          if (dq.size() == 0) chk("done_expected", 0, 1);
          else begin
            dn = dq.pop_front();
            chk("xfer_count", xfer_count, dn.c);
            chk("done_latency", cyc, dn.cyc);
            chk("gnt_cleared", gnt, 0);
            chk("m_ack_cleared", m_ack, 0);
          end
          have = 0;
        end
        p_sreq = s_req; p_mack = m_ack != 0; p_busy = busy;
      end
    end
    chk("master0_timeouts", mst[0].to, 0);
    chk("master1_timeouts", mst[1].to, 0);
    chk("slave_timeouts", sto, 0);
    chk("tie_window_found", tie_miss, 0);
    chk("drain", end_miss, 0);
    chk("grants_left", gq.size(), 0);
    chk("acks_left", aq.size(), 0);
    chk("dones_left", dq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
  initial begin
    int t;
    #1 rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    repeat (300) @(posedge clk);
    t = 0;
    while (!(m_ack != 0 && m_req == 2'b11) && t < 2000) begin @(negedge clk); t++; end
    tie_miss = t >= 2000;
    #1 rst = 1;
    #2 rst = 0;
    repeat (600) @(posedge clk);
    stop = 1;
    t = 0;
    while (!(mst[0].idle && mst[1].idle && !busy && !s_ack) && t < 1000) begin @(negedge clk); t++; end
    end_miss = t >= 1000;
    repeat (2) @(negedge clk);
    fin = 1;
  end
endmodule
